// File: rtl/voice_allocator.sv
// Polyphonic voice allocator: maps MIDI note-on/off requests onto voice slots with
// same-key retrigger, round-robin free-voice search and oldest-voice stealing.
module voice_allocator #(
  parameter int VOICES  = 32,
  parameter int V_WIDTH = $clog2(VOICES)
) (
  input  logic               reg_clk,
  input  logic               reset_reg_N,
  input  logic               on_req,
  input  logic               off_req,
  input  logic [7:0]         req_key,
  input  logic [7:0]         req_vel,
  output logic               req_ack,
  output logic               busy,
  input  logic [VOICES-1:0]  voice_free,
  output logic [VOICES-1:0]  keys_on,
  output logic               note_on,
  output logic [V_WIDTH-1:0] cur_key_adr,
  output logic [7:0]         cur_key_val,
  output logic [7:0]         cur_vel_on,
  output logic [7:0]         cur_vel_off,
  output logic [V_WIDTH:0]   active_keys,
  output logic               steal
);

  localparam logic [V_WIDTH-1:0] LAST_IDX = V_WIDTH'(VOICES - 1);

  typedef enum logic [1:0] {IDLE, SCAN, ISSUE} state_t;

  state_t state_q, state_d;

  logic               op_off_q;
  logic [7:0]         key_q;
  logic [7:0]         vel_q;
  logic [V_WIDTH-1:0] scan_idx_q;
  logic [V_WIDTH-1:0] scan_cnt_q;
  logic [V_WIDTH-1:0] rr_ptr_q;
  logic [7:0]         key_mem [VOICES];
  logic [V_WIDTH-1:0] age_mem [VOICES];

  logic               match_vld_q, match_vld_d;
  logic [V_WIDTH-1:0] match_idx_q, match_idx_d;
  logic               free_vld_q, free_vld_d;
  logic [V_WIDTH-1:0] free_idx_q, free_idx_d;
  logic [V_WIDTH-1:0] best_age_q, best_age_d;
  logic [V_WIDTH-1:0] best_idx_q, best_idx_d;

  logic               accept;
  logic               last_scan;
  logic [V_WIDTH-1:0] alloc_idx;
  logic               alloc_steal;

  function automatic logic [V_WIDTH-1:0] sat_inc(input logic [V_WIDTH-1:0] a);
    sat_inc = (a == LAST_IDX) ? a : a + 1'b1;
  endfunction

  function automatic logic [V_WIDTH-1:0] wrap_inc(input logic [V_WIDTH-1:0] a);
    wrap_inc = (a == LAST_IDX) ? '0 : a + 1'b1;
  endfunction

  function automatic logic [V_WIDTH:0] popcount(input logic [VOICES-1:0] v);
    popcount = '0;
    for (int i = 0; i < VOICES; i++) popcount = popcount + (V_WIDTH+1)'(v[i]);
  endfunction

  assign busy      = (state_q != IDLE);
  assign accept    = (state_q == IDLE) && (on_req || off_req);
  assign last_scan = (state_q == SCAN) && (scan_cnt_q == LAST_IDX);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (on_req || off_req) state_d = SCAN;
      SCAN:    if (scan_cnt_q == LAST_IDX) state_d = ISSUE;
      ISSUE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Per-voice scan step: the current voice is folded into the running candidates,
  // so on the last scan cycle the *_d values already cover every voice.
  always_comb begin
    match_vld_d = match_vld_q;
    match_idx_d = match_idx_q;
    free_vld_d  = free_vld_q;
    free_idx_d  = free_idx_q;
    best_age_d  = best_age_q;
    best_idx_d  = best_idx_q;
    if (state_q == SCAN) begin
      if (!match_vld_q && keys_on[scan_idx_q] && (key_mem[scan_idx_q] == key_q)) begin
        match_vld_d = 1'b1;
        match_idx_d = scan_idx_q;
      end
      if (!free_vld_q && voice_free[scan_idx_q] && !keys_on[scan_idx_q]) begin
        free_vld_d = 1'b1;
        free_idx_d = scan_idx_q;
      end
      if ((scan_cnt_q == '0) || (age_mem[scan_idx_q] > best_age_q)) begin
        best_age_d = age_mem[scan_idx_q];
        best_idx_d = scan_idx_q;
      end
    end
  end

  always_comb begin
    alloc_idx   = best_idx_d;
    alloc_steal = 1'b1;
    if (match_vld_d) begin
      alloc_idx   = match_idx_d;
      alloc_steal = 1'b0;
    end else if (free_vld_d) begin
      alloc_idx   = free_idx_d;
      alloc_steal = 1'b0;
    end
  end

  always_ff @(posedge reg_clk or negedge reset_reg_N) begin
    if (!reset_reg_N) begin
      state_q     <= IDLE;
      op_off_q    <= 1'b0;
      key_q       <= '0;
      vel_q       <= '0;
      scan_idx_q  <= '0;
      scan_cnt_q  <= '0;
      rr_ptr_q    <= '0;
      match_vld_q <= 1'b0;
      match_idx_q <= '0;
      free_vld_q  <= 1'b0;
      free_idx_q  <= '0;
      best_age_q  <= '0;
      best_idx_q  <= '0;
      req_ack     <= 1'b0;
      note_on     <= 1'b0;
      steal       <= 1'b0;
      keys_on     <= '0;
      cur_key_adr <= '0;
      cur_key_val <= '0;
      cur_vel_on  <= '0;
      cur_vel_off <= '0;
      active_keys <= '0;
      for (int i = 0; i < VOICES; i++) begin
        key_mem[i] <= '0;
        age_mem[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      req_ack     <= 1'b0;
      note_on     <= 1'b0;
      steal       <= 1'b0;
      active_keys <= popcount(keys_on);
      match_vld_q <= match_vld_d;
      match_idx_q <= match_idx_d;
      free_vld_q  <= free_vld_d;
      free_idx_q  <= free_idx_d;
      best_age_q  <= best_age_d;
      best_idx_q  <= best_idx_d;

      if (accept) begin
        op_off_q    <= off_req;
        key_q       <= req_key;
        vel_q       <= req_vel;
        scan_idx_q  <= rr_ptr_q;
        scan_cnt_q  <= '0;
        match_vld_q <= 1'b0;
        free_vld_q  <= 1'b0;
      end

      if (state_q == SCAN) begin
        scan_idx_q <= wrap_inc(scan_idx_q);
        scan_cnt_q <= scan_cnt_q + 1'b1;
      end

      // Commit on the edge into ISSUE so results are visible during the ack cycle.
      if (last_scan) begin
        req_ack <= 1'b1;
        if (!op_off_q) begin
          keys_on[alloc_idx]  <= 1'b1;
          note_on             <= 1'b1;
          steal               <= alloc_steal;
          cur_key_adr         <= alloc_idx;
          cur_key_val         <= key_q;
          cur_vel_on          <= vel_q;
          key_mem[alloc_idx]  <= key_q;
          rr_ptr_q            <= wrap_inc(alloc_idx);
          for (int i = 0; i < VOICES; i++) begin
            age_mem[i] <= (V_WIDTH'(i) == alloc_idx) ? '0 : sat_inc(age_mem[i]);
          end
        end else if (match_vld_d) begin
          keys_on[match_idx_d] <= 1'b0;
          cur_key_adr          <= match_idx_d;
          cur_vel_off          <= vel_q;
        end
      end
    end
  end

endmodule

// File: tb/tb_voice_allocator.sv
// Directed bench for voice_allocator with VOICES=4: a table of sequential requests
// plus hand-written reset-mid-scan, retrigger and simultaneous on/off sequences.
module tb_voice_allocator;
  localparam int VOICES = 4;
  localparam int VW     = 2;

  logic          reg_clk = 1'b0;
  logic          reset_reg_N;
  logic          on_req, off_req;
  logic [7:0]    req_key, req_vel;
  logic          req_ack, busy;
  logic [VOICES-1:0] voice_free, keys_on;
  logic          note_on;
  logic [VW-1:0] cur_key_adr;
  logic [7:0]    cur_key_val, cur_vel_on, cur_vel_off;
  logic [VW:0]   active_keys;
  logic          steal;

  voice_allocator #(.VOICES(VOICES), .V_WIDTH(VW)) dut (
    .reg_clk(reg_clk), .reset_reg_N(reset_reg_N),
    .on_req(on_req), .off_req(off_req), .req_key(req_key), .req_vel(req_vel),
    .req_ack(req_ack), .busy(busy), .voice_free(voice_free), .keys_on(keys_on),
    .note_on(note_on), .cur_key_adr(cur_key_adr), .cur_key_val(cur_key_val),
    .cur_vel_on(cur_vel_on), .cur_vel_off(cur_vel_off), .active_keys(active_keys),
    .steal(steal)
  );

  always #5 reg_clk = ~reg_clk;

  typedef struct {
    bit         is_off;
    logic [7:0] key;
    logic [7:0] vel;
    logic [3:0] free;
    logic [1:0] adr;
    logic [3:0] keys;
    bit         non;
    bit         stl;
    logic [7:0] kv;
    logic [7:0] von;
    logic [7:0] voff;
    logic [2:0] act;
  } vec_t;

  int total = 0;
  int bad   = 0;
  vec_t tbl[13];

  function automatic vec_t mk(bit is_off, int key, int vel, logic [3:0] free, int adr,
                              logic [3:0] keys, bit non, bit stl, int kv, int von,
                              int voff, int act);
    vec_t v;
    v.is_off = is_off; v.key = 8'(key); v.vel = 8'(vel); v.free = free;
    v.adr = 2'(adr); v.keys = keys; v.non = non; v.stl = stl;
    v.kv = 8'(kv); v.von = 8'(von); v.voff = 8'(voff); v.act = 3'(act);
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic wait_ack(output int lat);
    lat = -1;
    for (int c = 1; c <= 20; c++) begin
      @(posedge reg_clk);
      @(negedge reg_clk);
      if (req_ack === 1'b1) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic apply(input vec_t v, input string tag);
    int lat;
    voice_free = v.free;
    req_key    = v.key;
    req_vel    = v.vel;
    on_req     = !v.is_off;
    off_req    = v.is_off;
    wait_ack(lat);
    chk({tag, " latency"}, 32'(lat), 32'(VOICES + 1));
    chk({tag, " busy"}, 32'(busy), 32'd1);
    chk({tag, " note_on"}, 32'(note_on), 32'(v.non));
    chk({tag, " steal"}, 32'(steal), 32'(v.stl));
    chk({tag, " adr"}, 32'(cur_key_adr), 32'(v.adr));
    chk({tag, " keys_on"}, 32'(keys_on), 32'(v.keys));
    chk({tag, " key_val"}, 32'(cur_key_val), 32'(v.kv));
    chk({tag, " vel_on"}, 32'(cur_vel_on), 32'(v.von));
    chk({tag, " vel_off"}, 32'(cur_vel_off), 32'(v.voff));
    on_req  = 1'b0;
    off_req = 1'b0;
    @(posedge reg_clk);
    @(negedge reg_clk);
    chk({tag, " ack pulse"}, 32'(req_ack), 32'd0);
    chk({tag, " note_on pulse"}, 32'(note_on), 32'd0);
    chk({tag, " idle"}, 32'(busy), 32'd0);
    chk({tag, " active_keys"}, 32'(active_keys), 32'(v.act));
  endtask

  initial begin
    int lat;
    string tag;
    reset_reg_N = 1'b0;
    on_req = 1'b0; off_req = 1'b0;
    req_key = '0; req_vel = '0; voice_free = '0;

    //            off key vel free    adr keys    non stl kv  von  voff act
    tbl[0]  = mk(0, 60, 100, 4'b1111, 0, 4'b0001, 1, 0, 60, 100, 0,  1);
    tbl[1]  = mk(0, 62, 101, 4'b1111, 1, 4'b0011, 1, 0, 62, 101, 0,  2);
    tbl[2]  = mk(0, 64, 102, 4'b1111, 2, 4'b0111, 1, 0, 64, 102, 0,  3);
    tbl[3]  = mk(0, 65, 103, 4'b1111, 3, 4'b1111, 1, 0, 65, 103, 0,  4);
    tbl[4]  = mk(0, 67, 104, 4'b0000, 0, 4'b1111, 1, 1, 67, 104, 0,  4);
    tbl[5]  = mk(0, 64, 105, 4'b0000, 2, 4'b1111, 1, 0, 64, 105, 0,  4);
    tbl[6]  = mk(1, 62, 40,  4'b0000, 1, 4'b1101, 0, 0, 64, 105, 40, 3);
    tbl[7]  = mk(1, 70, 41,  4'b0000, 1, 4'b1101, 0, 0, 64, 105, 40, 3);
    tbl[8]  = mk(0, 70, 106, 4'b1111, 1, 4'b1111, 1, 0, 70, 106, 40, 4);
    tbl[9]  = mk(0, 71, 107, 4'b0010, 3, 4'b1111, 1, 1, 71, 107, 40, 4);
    tbl[10] = mk(1, 71, 42,  4'b0000, 3, 4'b0111, 0, 0, 71, 107, 42, 3);
    tbl[11] = mk(0, 72, 108, 4'b0000, 0, 4'b0111, 1, 1, 72, 108, 42, 3);
    tbl[12] = mk(0, 73, 109, 4'b1000, 3, 4'b1111, 1, 0, 73, 109, 42, 4);

    @(negedge reg_clk);
    @(negedge reg_clk);
    chk("reset keys_on", 32'(keys_on), 32'd0);
    chk("reset ack", 32'(req_ack), 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset active", 32'(active_keys), 32'd0);
    reset_reg_N = 1'b1;
    @(negedge reg_clk);

    for (int i = 0; i < 13; i++) begin
      tag = $sformatf("vec%0d", i);
      apply(tbl[i], tag);
    end

    // Reset asserted two cycles into a scan clears everything without a clock edge.
    voice_free = 4'b1111; req_key = 8'd80; req_vel = 8'd55; on_req = 1'b1;
    @(posedge reg_clk); @(negedge reg_clk);
    @(posedge reg_clk); @(negedge reg_clk);
    chk("midscan busy", 32'(busy), 32'd1);
    #1 reset_reg_N = 1'b0;
    #1;
    chk("rst keys_on", 32'(keys_on), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst active", 32'(active_keys), 32'd0);
    chk("rst adr", 32'(cur_key_adr), 32'd0);
    chk("rst key_val", 32'(cur_key_val), 32'd0);
    chk("rst vel_on", 32'(cur_vel_on), 32'd0);
    chk("rst vel_off", 32'(cur_vel_off), 32'd0);
    on_req = 1'b0;
    @(negedge reg_clk);
    reset_reg_N = 1'b1;
    @(negedge reg_clk);

    apply(mk(0, 60, 100, 4'b1111, 0, 4'b0001, 1, 0, 60, 100, 0, 1), "post-rst on");
    apply(mk(0, 60, 77,  4'b1111, 0, 4'b0001, 1, 0, 60, 77,  0, 1), "retrigger");

    // Simultaneous off and on for key 60: the off must be serviced first.
    voice_free = 4'b1111; req_key = 8'd60; req_vel = 8'd90;
    on_req = 1'b1; off_req = 1'b1;
    wait_ack(lat);
    chk("both off latency", 32'(lat), 32'(VOICES + 1));
    chk("both off note_on", 32'(note_on), 32'd0);
    chk("both off keys_on", 32'(keys_on), 32'b0000);
    chk("both off vel_off", 32'(cur_vel_off), 32'd90);
    off_req = 1'b0;
    wait_ack(lat);
    chk("both on latency", 32'(lat), 32'(VOICES + 2));
    chk("both on note_on", 32'(note_on), 32'd1);
    chk("both on adr", 32'(cur_key_adr), 32'd1);
    chk("both on keys_on", 32'(keys_on), 32'b0010);
    chk("both on vel_on", 32'(cur_vel_on), 32'd90);
    chk("both on steal", 32'(steal), 32'd0);
    on_req = 1'b0;
    @(posedge reg_clk); @(negedge reg_clk);
    chk("both active", 32'(active_keys), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/voice_allocator.md
Name: voice_allocator

Overview:
- Assigns incoming MIDI note-on/note-off requests to the VOICES polyphonic voice slots of the synth engine.
- Produces the note event bus the engine consumes: keys_on, note_on, cur_key_adr, cur_key_val, cur_vel_on, cur_vel_off and active_keys.
- Sits between the MIDI decoder and the synth engine. Uses voice_free from the envelope generator to find idle slots.
- Performs same-key retrigger, round-robin free-voice search and oldest-voice stealing.

Parameters:
- VOICES, 32, number of voice slots.
- V_WIDTH, utils::clogb2(VOICES), voice index width.

Ports:
- reg_clk  in  1  system clock.
- reset_reg_N  in  1  asynchronous active-low reset.
- on_req  in  1  note-on request; held with req_key/req_vel until req_ack.
- off_req  in  1  note-off request; held with req_key/req_vel until req_ack.
- req_key  in  8  MIDI key number.
- req_vel  in  8  velocity (on or off).
- req_ack  out  1  one-cycle pulse: request completed.
- busy  out  1  high while not IDLE.
- voice_free  in  VOICES  per-voice envelope idle flag from env gen.
- keys_on  out  VOICES  per-voice gate.
- note_on  out  1  one-cycle pulse on voice allocation.
- cur_key_adr  out  V_WIDTH  voice index of the last event.
- cur_key_val  out  8  key of the last note-on.
- cur_vel_on  out  8  velocity of the last note-on.
- cur_vel_off  out  8  velocity of the last note-off.
- active_keys  out  V_WIDTH+1  popcount of keys_on.
- steal  out  1  one-cycle pulse, coincident with note_on, when a non-free voice was taken.

Behaviour:
- Reset (async, any state, including mid-scan): all outputs 0; state IDLE; rr_ptr 0; all voice ages 0; stored keys 0.
- States: IDLE, SCAN, ISSUE.
- IDLE: if off_req, accept note-off. Else if on_req, accept note-on. off_req wins when both are high; on_req stays pending and is accepted on the next IDLE cycle.
  - Accept cycle T: latch req_key, req_vel and the op; set scan index to rr_ptr; go to SCAN.
- SCAN: exactly VOICES cycles (T+1..T+VOICES), one voice per cycle, index = (rr_ptr + n) mod VOICES.
  - voice_free is sampled at the scan cycle of each voice.
- Note-on candidate priority, highest first:
  - (a) first voice with keys_on=1 and stored key == req_key (retrigger);
  - (b) first voice with voice_free=1 and keys_on=0;
  - (c) voice with maximum age; ties go to the first in scan order.
- Note-off: first voice with keys_on=1 and stored key == req_key. If none is found, there is no change.
- ISSUE at T+VOICES+1: req_ack=1 for one cycle; return to IDLE at the next cycle. Every request, found or not, gets exactly one req_ack; the requester drops its request after req_ack.
  - Note-on to voice v:
    - keys_on[v]=1; note_on=1 for one cycle; steal=1 only for case (c);
    - cur_key_adr=v; cur_key_val=req_key; cur_vel_on=req_vel; stored key[v]=req_key;
    - rr_ptr=(v+1) mod VOICES;
    - age[v]=0; every other voice ages +1, saturating at VOICES-1.
  - Note-off found at v: keys_on[v]=0; cur_key_adr=v; cur_vel_off=req_vel; note_on stays 0; ages unchanged.
  - Note-off not found: outputs unchanged except req_ack.
- Total latency, accept to ack: VOICES+1 cycles. Throughput: one request per VOICES+2 cycles.
- active_keys: registered popcount of keys_on, lagging keys_on by one cycle. Range 0..VOICES with no wrap (width V_WIDTH+1).
- cur_* outputs hold between events.
- rr_ptr wraps from VOICES-1 to 0.
- Requests arriving while busy are ignored until IDLE; they are not lost, because they are held.

Test Plan:
- VOICES=4, reset, all voice_free=1:
  - on_req key 60 vel 100 -> 5 cycles after accept: note_on pulse, cur_key_adr=0, keys_on=0001, cur_key_val=60, cur_vel_on=100, steal=0;
  - active_keys=1 one cycle later.
- Keys 60, 62, 64, 65 on, then key 67 with voice_free=0000 -> steal=1, voice 0 (age 3) taken, cur_key_adr=0, keys_on=1111, active_keys stays 4.
- Key 60 on at voice 0, then key 60 on again -> voice 0 retriggered, note_on pulse, steal=0, keys_on=0001.
- Key 62 on at voice 1, then off_req key 62 vel 40 -> keys_on bit1 cleared, cur_vel_off=40, cur_key_adr=1, no note_on pulse, req_ack.
- off_req key 70 with no match -> req_ack after 5 cycles, keys_on unchanged.
- on_req and off_req high together -> off serviced first, then on.
- reset_reg_N low mid-SCAN -> all outputs 0 immediately; after release, a new on_req allocates voice 0.
